mac3_window_param: RTL and testbench

- Parametrised successor of the three-sample multiply-add stage. It collects consecutive valid input samples a, b, c and emits a selectable combination, a*b+c by default.
- Adds configurable width, signed/unsigned arithmetic, a mode select, saturation with overflow flags, sliding-window operation, synchronous clear and an output counter.
- Sits in the datapath after the input sampler; its valido/data_out contract is checked by the team's property module.

---
 rtl/mac3_window_param.sv | 126 ++++++++++++
 tb/tb_mac3_window_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mac3_window_param.sv
// Sliding three-sample multiply-add: a*b+c, a*b-c, a*b or a*b+data_out over consecutive valid samples,
// with saturation to the OUT_W range, overflow flags and a wrapping result counter.
module mac3_window_param #(
  parameter int WIDTH  = 32,
  parameter int OUT_W  = 2*WIDTH+1,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clr,
  input  logic             validi,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  output logic             valido,
  output logic [OUT_W-1:0] data_out,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] out_cnt
);

  // Working width covers the full product even when OUT_W is narrower than 2*WIDTH.
  localparam int PW = 2*WIDTH;
  localparam int SW = ((PW > OUT_W) ? PW : OUT_W) + 2;

  localparam logic signed [SW-1:0] MAXV = SIGNED ?
    {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}} : {{(SW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [SW-1:0] MINV = SIGNED ?
    {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}} : {SW{1'b0}};

  function automatic logic signed [SW-1:0] extIn(input logic [WIDTH-1:0] v);
    extIn = {{(SW-WIDTH){SIGNED & v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] extOut(input logic [OUT_W-1:0] v);
    extOut = {{(SW-OUT_W){SIGNED & v[OUT_W-1]}}, v};
  endfunction

  logic [1:0]       streak_q, streak_d;
  logic [WIDTH-1:0] b_q, b_d, c_q, c_d;
  logic             valido_q, valido_d, ovf_q, ovf_d, sticky_q, sticky_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [SW-1:0] opA, opB, opC, opD, prod, sum;
  logic                 satHi, satLo;
  logic [OUT_W-1:0]     res;

  // The oldest sample of the window is b_q, so a separate "a" register is never needed.
  always_comb begin
    opA  = extIn(b_q);
    opB  = extIn(c_q);
    opC  = extIn(data_in);
    opD  = extOut(data_out_q);
    prod = opA * opB;
    case (mode)
      2'd0:    sum = prod + opC;
      2'd1:    sum = prod - opC;
      2'd2:    sum = prod;
      default: sum = prod + opD;
    endcase
    satHi = (sum > MAXV);
    satLo = (sum < MINV);
    if (satHi)      res = MAXV[OUT_W-1:0];
    else if (satLo) res = MINV[OUT_W-1:0];
    else            res = sum[OUT_W-1:0];
  end

  always_comb begin
    streak_d   = streak_q;
    b_d        = b_q;
    c_d        = c_q;
    valido_d   = 1'b0;
    ovf_d      = 1'b0;
    data_out_d = data_out_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    if (clr) begin
      streak_d = 2'd0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (validi) begin
      b_d      = c_q;
      c_d      = data_in;
      streak_d = (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
      if (streak_q >= 2'd2) begin
        valido_d   = 1'b1;
        data_out_d = res;
        ovf_d      = satHi | satLo;
        sticky_d   = sticky_q | satHi | satLo;
        cnt_d      = cnt_q + CNT_W'(1);
      end
    end else begin
      streak_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      streak_q   <= 2'd0;
      b_q        <= '0;
      c_q        <= '0;
      valido_q   <= 1'b0;
      ovf_q      <= 1'b0;
      data_out_q <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      streak_q   <= streak_d;
      b_q        <= b_d;
      c_q        <= c_d;
      valido_q   <= valido_d;
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign valido     = valido_q;
  assign data_out   = data_out_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;
  assign out_cnt    = cnt_q;

endmodule

// File: tb/tb_mac3_window_param.sv
// Directed bench for mac3_window_param: a 32-bit unsigned instance driven from a vector table,
// plus 8-bit unsigned (2-bit counter) and 8-bit signed instances for saturation, clear and wrap.
module tb_mac3_window_param;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        clr0 = 1'b0, v0 = 1'b0;
  logic [1:0]  m0 = 2'd0;
  logic [31:0] d0 = '0;
  logic        vo0, ovf0, st0;
  logic [64:0] do0;
  logic [15:0] cnt0;

  logic        clr1 = 1'b0, v1 = 1'b0;
  logic [1:0]  m1 = 2'd0;
  logic [7:0]  d1 = '0;
  logic        vo1, ovf1, st1;
  logic [11:0] do1;
  logic [1:0]  cnt1;

  logic        clr2 = 1'b0, v2 = 1'b0;
  logic [1:0]  m2 = 2'd0;
  logic [7:0]  d2 = '0;
  logic        vo2, ovf2, st2;
  logic [8:0]  do2;
  logic [15:0] cnt2;

  mac3_window_param #(.WIDTH(32)) dut0 (
    .clk(clk), .rst_(rst_), .clr(clr0), .validi(v0), .data_in(d0), .mode(m0),
    .valido(vo0), .data_out(do0), .ovf(ovf0), .ovf_sticky(st0), .out_cnt(cnt0));

  mac3_window_param #(.WIDTH(8), .OUT_W(12), .SIGNED(1'b0), .CNT_W(2)) dut1 (
    .clk(clk), .rst_(rst_), .clr(clr1), .validi(v1), .data_in(d1), .mode(m1),
    .valido(vo1), .data_out(do1), .ovf(ovf1), .ovf_sticky(st1), .out_cnt(cnt1));

  mac3_window_param #(.WIDTH(8), .OUT_W(9), .SIGNED(1'b1), .CNT_W(16)) dut2 (
    .clk(clk), .rst_(rst_), .clr(clr2), .validi(v2), .data_in(d2), .mode(m2),
    .valido(vo2), .data_out(do2), .ovf(ovf2), .ovf_sticky(st2), .out_cnt(cnt2));

  typedef struct packed {
    logic        v;
    logic        c;
    logic [1:0]  m;
    logic [31:0] d;
    logic        expV;
    logic [64:0] expD;
    logic        expOvf;
    logic [15:0] expCnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic c, input logic [1:0] m, input logic [31:0] d,
                              input logic ev, input logic [64:0] ed, input logic eo, input logic [15:0] ec);
    vec_t r;
    r.v = v; r.c = c; r.m = m; r.d = d;
    r.expV = ev; r.expD = ed; r.expOvf = eo; r.expCnt = ec;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus1(input logic v, input logic c, input logic [1:0] m, input logic [7:0] d);
    v1 = v; clr1 = c; m1 = m; d1 = d;
    tick();
  endtask

  task automatic applyStimulus2(input logic v, input logic [7:0] d);
    v2 = v; clr2 = 1'b0; m2 = 2'd0; d2 = d;
    tick();
  endtask

  task automatic checkDut1(input string tag, input logic ev, input logic [11:0] ed, input logic eo,
                           input logic es, input logic [1:0] ec);
    checkOutput({tag, ".valido"}, 80'(vo1), 80'(ev));
    checkOutput({tag, ".data_out"}, 80'(do1), 80'(ed));
    checkOutput({tag, ".ovf"}, 80'(ovf1), 80'(eo));
    checkOutput({tag, ".sticky"}, 80'(st1), 80'(es));
    checkOutput({tag, ".out_cnt"}, 80'(cnt1), 80'(ec));
  endtask

  task automatic checkDut2(input string tag, input logic ev, input logic [8:0] ed, input logic eo, input logic es);
    checkOutput({tag, ".valido"}, 80'(vo2), 80'(ev));
    checkOutput({tag, ".data_out"}, 80'(do2), 80'(ed));
    checkOutput({tag, ".ovf"}, 80'(ovf2), 80'(eo));
    checkOutput({tag, ".sticky"}, 80'(st2), 80'(es));
  endtask

  initial begin
    // basic, sliding, gap, modes (mode only honoured on the third sample), clr overriding validi
    tbl.push_back(mk(1,0,0,3, 0, 0,0,0));
    tbl.push_back(mk(1,0,0,4, 0, 0,0,0));
    tbl.push_back(mk(1,0,0,5, 1,17,0,1));
    tbl.push_back(mk(0,0,0,9, 0,17,0,1));
    tbl.push_back(mk(1,0,0,2, 0,17,0,1));
    tbl.push_back(mk(1,0,0,3, 0,17,0,1));
    tbl.push_back(mk(1,0,0,4, 1,10,0,2));
    tbl.push_back(mk(1,0,0,5, 1,17,0,3));
    tbl.push_back(mk(0,0,0,0, 0,17,0,3));
    tbl.push_back(mk(1,0,0,1, 0,17,0,3));
    tbl.push_back(mk(1,0,0,1, 0,17,0,3));
    tbl.push_back(mk(0,0,0,1, 0,17,0,3));
    tbl.push_back(mk(1,0,0,1, 0,17,0,3));
    tbl.push_back(mk(1,0,0,1, 0,17,0,3));
    tbl.push_back(mk(0,0,0,0, 0,17,0,3));
    tbl.push_back(mk(1,0,2,6, 0,17,0,3));
    tbl.push_back(mk(1,0,2,7, 0,17,0,3));
    tbl.push_back(mk(1,0,1,2, 1,40,0,4));
    tbl.push_back(mk(0,0,0,0, 0,40,0,4));
    tbl.push_back(mk(1,0,0,6, 0,40,0,4));
    tbl.push_back(mk(1,0,0,7, 0,40,0,4));
    tbl.push_back(mk(1,0,2,2, 1,42,0,5));
    tbl.push_back(mk(0,0,0,0, 0,42,0,5));
    tbl.push_back(mk(1,0,0,1, 0,42,0,5));
    tbl.push_back(mk(1,0,0,1, 0,42,0,5));
    tbl.push_back(mk(1,0,3,1, 1,43,0,6));
    tbl.push_back(mk(0,0,0,0, 0,43,0,6));
    tbl.push_back(mk(1,0,0,3, 0,43,0,6));
    tbl.push_back(mk(1,0,0,4, 0,43,0,6));
    tbl.push_back(mk(1,1,0,5, 0,43,0,0));
    tbl.push_back(mk(1,0,0,6, 0,43,0,0));
    tbl.push_back(mk(1,0,0,7, 0,43,0,0));
    tbl.push_back(mk(1,0,0,8, 1,50,0,1));
    tbl.push_back(mk(0,0,0,0, 0,50,0,1));

    // reset held while inputs toggle
    rst_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v0 = i[0]; v1 = i[0]; v2 = i[0];
      d0 = 32'd5; d1 = 8'd5; d2 = 8'd5;
      tick();
      checkOutput($sformatf("rst%0d.valido", i), 80'(vo0), 80'(0));
      checkOutput($sformatf("rst%0d.data_out", i), 80'(do0), 80'(0));
      checkOutput($sformatf("rst%0d.out_cnt", i), 80'(cnt0), 80'(0));
      checkOutput($sformatf("rst%0d.dut1_valido", i), 80'(vo1), 80'(0));
    end
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    rst_ = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      v0 = tbl[i].v; clr0 = tbl[i].c; m0 = tbl[i].m; d0 = tbl[i].d;
      tick();
      checkOutput($sformatf("row%0d.valido", i), 80'(vo0), 80'(tbl[i].expV));
      checkOutput($sformatf("row%0d.data_out", i), 80'(do0), 80'(tbl[i].expD));
      checkOutput($sformatf("row%0d.ovf", i), 80'(ovf0), 80'(tbl[i].expOvf));
      checkOutput($sformatf("row%0d.out_cnt", i), 80'(cnt0), 80'(tbl[i].expCnt));
      checkOutput($sformatf("row%0d.sticky", i), 80'(st0), 80'(0));
    end
    v0 = 1'b0; clr0 = 1'b0;

    // unsigned saturation, then five results wrapping a 2-bit counter
    applyStimulus1(1,0,0,8'd200); checkDut1("u0", 0,   0,0,0,0);
    applyStimulus1(1,0,0,8'd200); checkDut1("u1", 0,   0,0,0,0);
    applyStimulus1(1,0,0,8'd10);  checkDut1("u2", 1,4095,1,1,1);
    applyStimulus1(1,0,0,8'd1);   checkDut1("u3", 1,2001,0,1,2);
    applyStimulus1(1,0,0,8'd2);   checkDut1("u4", 1,  12,0,1,3);
    applyStimulus1(1,0,0,8'd3);   checkDut1("u5", 1,   5,0,1,0);
    applyStimulus1(1,0,0,8'd4);   checkDut1("u6", 1,  10,0,1,1);
    applyStimulus1(0,0,0,8'd0);   checkDut1("u7", 0,  10,0,1,1);
    // clr between the second and third sample
    applyStimulus1(1,0,0,8'd1);   checkDut1("c0", 0,  10,0,1,1);
    applyStimulus1(1,0,0,8'd2);   checkDut1("c1", 0,  10,0,1,1);
    applyStimulus1(0,1,0,8'd0);   checkDut1("c2", 0,  10,0,0,0);
    applyStimulus1(1,0,0,8'd3);   checkDut1("c3", 0,  10,0,0,0);
    applyStimulus1(0,0,0,8'd0);   checkDut1("c4", 0,  10,0,0,0);
    // unsigned mode 1 going negative clamps to zero
    applyStimulus1(1,0,0,8'd1);   checkDut1("n0", 0,  10,0,0,0);
    applyStimulus1(1,0,0,8'd1);   checkDut1("n1", 0,  10,0,0,0);
    applyStimulus1(1,0,1,8'd5);   checkDut1("n2", 1,   0,1,1,1);
    applyStimulus1(0,0,0,8'd0);   checkDut1("n3", 0,   0,0,1,1);

    // signed: negative saturation, in-range negative result, positive saturation
    applyStimulus2(1,8'h80); checkDut2("s0", 0,9'h000,0,0);
    applyStimulus2(1,8'h7F); checkDut2("s1", 0,9'h000,0,0);
    applyStimulus2(1,8'h9C); checkDut2("s2", 1,9'h100,1,1);
    applyStimulus2(0,8'h00); checkDut2("s3", 0,9'h100,0,1);
    applyStimulus2(1,8'hFD); checkDut2("s4", 0,9'h100,0,1);
    applyStimulus2(1,8'h04); checkDut2("s5", 0,9'h100,0,1);
    applyStimulus2(1,8'hFB); checkDut2("s6", 1,9'h1EF,0,1);
    applyStimulus2(0,8'h00); checkDut2("s7", 0,9'h1EF,0,1);
    applyStimulus2(1,8'h7F); checkDut2("s8", 0,9'h1EF,0,1);
    applyStimulus2(1,8'h7F); checkDut2("s9", 0,9'h1EF,0,1);
    applyStimulus2(1,8'h7F); checkDut2("s10",1,9'h0FF,1,1);
    checkOutput("s10.out_cnt", 80'(cnt2), 80'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
